// File: rtl/pcie_pkg.sv
// Shared types and word-field positions for the destination split/merge datapath.
package pcie_pkg;

    localparam int DW        = 6;
    localparam int CLASS_BIT = DW - 1;
    localparam int DEST_BIT  = DW - 2;

    typedef enum logic [2:0] {
        RESET,
        INIT,
        IDLE,
        ACTIVE,
        ERROR
    } state_e;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-requester round-robin arbiter: one-hot grant, pointer moves to the other side after a grant.
// With WEIGHTED_RR_EN each side keeps the pointer for weight+1 consecutive grants.
module rr_arbiter_2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_i,
`ifdef WEIGHTED_RR_EN
    input  logic [1:0] weight0_i,
    input  logic [1:0] weight1_i,
`endif
    output logic [1:0] gnt_o
);

    logic ptr_q, ptr_d;
    logic gnt_idx;

    always_comb begin
        gnt_o = req_i;
        if (req_i == 2'b11) begin
            gnt_o = ptr_q ? 2'b10 : 2'b01;
        end
    end

    assign gnt_idx = gnt_o[1];

`ifdef WEIGHTED_RR_EN
    logic [2:0] burst_q, burst_d;
    logic [2:0] run;
    logic [1:0] wsel;

    // run counts consecutive grants to the side currently holding the pointer
    always_comb begin
        ptr_d   = ptr_q;
        burst_d = burst_q;
        wsel    = gnt_idx ? weight1_i : weight0_i;
        run     = (gnt_idx == ptr_q) ? burst_q + 3'd1 : 3'd1;
        if (|gnt_o) begin
            if (run > {1'b0, wsel}) begin
                ptr_d   = ~gnt_idx;
                burst_d = 3'd0;
            end else begin
                ptr_d   = gnt_idx;
                burst_d = run;
            end
        end else if (!req_i[ptr_q]) begin
            burst_d = 3'd0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            burst_q <= 3'd0;
        end else begin
            burst_q <= burst_d;
        end
    end
`else
    assign ptr_d = (|gnt_o) ? ~gnt_idx : ptr_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/dest_merge_arbiter.sv
// Merges the D0/D1 destination FIFOs into one egress word stream with misroute checking.
// Macro WEIGHTED_RR_EN adds weight_D0/weight_D1 ports for weighted round-robin.
module dest_merge_arbiter
    import pcie_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             init,
    input  logic [1:0]       umbral_out,
    input  logic             empty_D0,
    input  logic             empty_D1,
    input  logic [DW-1:0]    data_D0,
    input  logic [DW-1:0]    data_D1,
    input  logic [1:0]       egress_count,
`ifdef WEIGHTED_RR_EN
    input  logic [1:0]       weight_D0,
    input  logic [1:0]       weight_D1,
`endif
    output logic             pop_D0,
    output logic             pop_D1,
    output logic             push_out,
    output logic [DW-1:0]    data_out,
    output logic [CNT_W-1:0] cnt_D0,
    output logic [CNT_W-1:0] cnt_D1,
    output logic             active_out,
    output logic             idle_out,
    output logic             error_out
);

    state_e           state_q, state_d;
    logic [1:0]       umbral_q;
    logic             push_q;
    logic [DW-1:0]    data_q;
    logic [CNT_W-1:0] cnt0_q, cnt1_q;
    logic             active_q, idle_q, error_q;
    logic             active_d, idle_d, error_d;
    logic             grant_en;
    logic [1:0]       req, gnt;
    logic [DW-1:0]    pop_word;
    logic             misroute;

    // grants only while ACTIVE and below the egress threshold; ERROR never pops
    assign grant_en = (state_q == ACTIVE) && (egress_count < umbral_q);
    assign req      = {~empty_D1, ~empty_D0} & {2{grant_en}};

`ifdef WEIGHTED_RR_EN
    logic [1:0] weight0_q, weight1_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            weight0_q <= 2'd0;
            weight1_q <= 2'd0;
        end else if (state_q == INIT) begin
            weight0_q <= weight_D0;
            weight1_q <= weight_D1;
        end
    end
`endif

    rr_arbiter_2 u_arb (
        .clk       (clk),
        .rst       (reset),
        .req_i     (req),
`ifdef WEIGHTED_RR_EN
        .weight0_i (weight0_q),
        .weight1_i (weight1_q),
`endif
        .gnt_o     (gnt)
    );

    assign pop_word = gnt[1] ? data_D1 : data_D0;
    assign misroute = (gnt[0] && data_D0[DEST_BIT]) || (gnt[1] && !data_D1[DEST_BIT]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RESET;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RESET:   state_d = INIT;
            INIT:    if (!init) state_d = IDLE;
            IDLE:    if (!empty_D0 || !empty_D1) state_d = ACTIVE;
            ACTIVE: begin
                if (misroute) begin
                    state_d = ERROR;
                end else if (empty_D0 && empty_D1 && !push_q) begin
                    state_d = IDLE;
                end
            end
            ERROR:   state_d = ERROR;
            default: state_d = RESET;
        endcase
        if (init) begin
            state_d = INIT;
        end
    end

    always_comb begin
        pop_D0   = gnt[0];
        pop_D1   = gnt[1];
        active_d = (state_d == ACTIVE);
        idle_d   = (state_d == IDLE);
        error_d  = (state_d == ERROR);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            umbral_q <= 2'd0;
            push_q   <= 1'b0;
            data_q   <= '0;
            cnt0_q   <= '0;
            cnt1_q   <= '0;
            active_q <= 1'b0;
            idle_q   <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            if (state_q == INIT) begin
                umbral_q <= umbral_out;
            end
            push_q <= |gnt;
            if (|gnt) begin
                data_q <= pop_word;
            end
            if (gnt[0]) begin
                cnt0_q <= cnt0_q + CNT_W'(1);
            end
            if (gnt[1]) begin
                cnt1_q <= cnt1_q + CNT_W'(1);
            end
            active_q <= active_d;
            idle_q   <= idle_d;
            error_q  <= error_d;
        end
    end

    assign push_out   = push_q;
    assign data_out   = data_q;
    assign cnt_D0     = cnt0_q;
    assign cnt_D1     = cnt1_q;
    assign active_out = active_q;
    assign idle_out   = idle_q;
    assign error_out  = error_q;

endmodule

// File: tb/tb_dest_merge_arbiter.sv
// Bench for dest_merge_arbiter: FIFO queues feed the DUT, a queue-based reference model predicts every cycle.
module tb_dest_merge_arbiter;

    localparam int CNT_W = 8;
    localparam int DEST  = 4;
    localparam int S_RST = 0, S_INIT = 1, S_IDLE = 2, S_ACT = 3, S_ERR = 4;

    typedef struct {
        int umb;
        int egr;
        bit exp_pop;
    } thr_t;

    logic             clk, reset, init;
    logic [1:0]       umbral_out, egress_count;
    logic             empty_D0, empty_D1;
    logic [5:0]       data_D0, data_D1;
    logic             pop_D0, pop_D1, push_out;
    logic [5:0]       data_out;
    logic [CNT_W-1:0] cnt_D0, cnt_D1;
    logic             active_out, idle_out, error_out;
`ifdef WEIGHTED_RR_EN
    logic [1:0]       weight_D0, weight_D1;
    int               m_w0, m_w1, m_run;
`endif

    int         errors = 0;
    int         checks = 0;
    int         dut_pops;
    int         m_st, m_umb, m_pref, m_c0, m_c1;
    bit         m_push;
    logic [5:0] m_data;
    logic [5:0] q0[$], q1[$], got[$], exp_q[$];

    dest_merge_arbiter #(.CNT_W(CNT_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .init         (init),
        .umbral_out   (umbral_out),
        .empty_D0     (empty_D0),
        .empty_D1     (empty_D1),
        .data_D0      (data_D0),
        .data_D1      (data_D1),
        .egress_count (egress_count),
`ifdef WEIGHTED_RR_EN
        .weight_D0    (weight_D0),
        .weight_D1    (weight_D1),
`endif
        .pop_D0       (pop_D0),
        .pop_D1       (pop_D1),
        .push_out     (push_out),
        .data_out     (data_out),
        .cnt_D0       (cnt_D0),
        .cnt_D1       (cnt_D1),
        .active_out   (active_out),
        .idle_out     (idle_out),
        .error_out    (error_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_zero(input string name);
        chk({name, "_push"},   push_out,   0);
        chk({name, "_data"},   data_out,   0);
        chk({name, "_cnt0"},   cnt_D0,     0);
        chk({name, "_cnt1"},   cnt_D1,     0);
        chk({name, "_active"}, active_out, 0);
        chk({name, "_idle"},   idle_out,   0);
        chk({name, "_error"},  error_out,  0);
        chk({name, "_pop0"},   pop_D0,     0);
        chk({name, "_pop1"},   pop_D1,     0);
    endtask

    task automatic model_reset();
        m_st = S_RST; m_umb = 0; m_pref = 0; m_c0 = 0; m_c1 = 0;
        m_push = 1'b0; m_data = '0;
`ifdef WEIGHTED_RR_EN
        m_w0 = 0; m_w1 = 0; m_run = 0;
`endif
    endtask

    task automatic drive();
        empty_D0 = (q0.size() == 0);
        empty_D1 = (q1.size() == 0);
        data_D0  = empty_D0 ? 6'h00 : q0[0];
        data_D1  = empty_D1 ? 6'h00 : q1[0];
    endtask

    // One clock: check combinational pops at negedge, advance model, check registered outputs after posedge.
    task automatic cycle();
        int         g, nst;
        bit         en, both_empty;
        logic [5:0] w;
`ifdef WEIGHTED_RR_EN
        int         run;
`endif
        drive();
        @(negedge clk);
        en         = (m_st == S_ACT) && (int'(egress_count) < m_umb);
        both_empty = (q0.size() == 0) && (q1.size() == 0);
        g = -1;
        if (en && q0.size() != 0 && q1.size() != 0) g = m_pref;
        else if (en && q0.size() != 0)              g = 0;
        else if (en && q1.size() != 0)              g = 1;
        chk("pop_D0", pop_D0, g == 0);
        chk("pop_D1", pop_D1, g == 1);
        dut_pops += int'(pop_D0) + int'(pop_D1);
        w = '0;
        if (g == 0) w = q0.pop_front();
        else if (g == 1) w = q1.pop_front();
        nst = m_st;
        case (m_st)
            S_RST:  nst = S_INIT;
            S_INIT: if (!init) nst = S_IDLE;
            S_IDLE: if (!both_empty) nst = S_ACT;
            S_ACT: begin
                if (g >= 0 && (w[DEST] != (g == 1))) nst = S_ERR;
                else if (both_empty && !m_push) nst = S_IDLE;
            end
            default: ;
        endcase
        if (init) nst = S_INIT;
`ifdef WEIGHTED_RR_EN
        if (g >= 0) begin
            run = (g == m_pref) ? m_run + 1 : 1;
            if (run > ((g == 0) ? m_w0 : m_w1)) begin
                m_pref = 1 - g; m_run = 0;
            end else begin
                m_pref = g; m_run = run;
            end
        end else begin
            m_run = 0;
        end
        if (m_st == S_INIT) begin
            m_w0 = int'(weight_D0); m_w1 = int'(weight_D1);
        end
`else
        if (g >= 0) m_pref = 1 - g;
`endif
        if (m_st == S_INIT) m_umb = int'(umbral_out);
        m_push = (g >= 0);
        if (g >= 0) m_data = w;
        if (g == 0) m_c0 = (m_c0 + 1) % (1 << CNT_W);
        if (g == 1) m_c1 = (m_c1 + 1) % (1 << CNT_W);
        m_st = nst;
        @(posedge clk);
        #1;
        if (push_out === 1'b1) got.push_back(data_out);
        chk("push_out",   push_out,   m_push);
        chk("data_out",   data_out,   m_data);
        chk("active_out", active_out, m_st == S_ACT);
        chk("idle_out",   idle_out,   m_st == S_IDLE);
        chk("error_out",  error_out,  m_st == S_ERR);
        chk("cnt_D0",     cnt_D0,     m_c0);
        chk("cnt_D1",     cnt_D1,     m_c1);
    endtask

    task automatic reset_dut();
        reset = 1'b1;
        #1;
        chk_zero("rst");
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic bring_up(input int umb);
        q0.delete(); q1.delete();
        reset_dut();
        init = 1'b1; umbral_out = 2'(umb); egress_count = 2'd0;
        cycle(); cycle();
        init = 1'b0;
        cycle();
        chk("bringup_idle", idle_out, 1);
        got.delete();
    endtask

    task automatic run_until_idle(input string name, input int budget);
        int n = 0;
        while (!(idle_out === 1'b1 && q0.size() == 0 && q1.size() == 0) && n < budget) begin
            cycle();
            n++;
        end
        chk({name, "_reach_idle"}, idle_out === 1'b1 && q0.size() == 0 && q1.size() == 0, 1);
    endtask

    task automatic chk_seq(input string name);
        chk({name, "_len"}, got.size(), exp_q.size());
        for (int k = 0; k < exp_q.size(); k++) begin
            chk(name, (k < got.size()) ? {26'd0, got[k]} : 32'hDEAD, exp_q[k]);
        end
    endtask

    initial begin
        thr_t       tv[8];
        logic [5:0] w;
        tv[0] = '{3, 0, 1'b1};
        tv[1] = '{3, 2, 1'b1};
        tv[2] = '{3, 3, 1'b0};
        tv[3] = '{2, 2, 1'b0};
        tv[4] = '{2, 1, 1'b1};
        tv[5] = '{0, 0, 1'b0};
        tv[6] = '{1, 0, 1'b1};
        tv[7] = '{1, 1, 1'b0};

        init = 1'b0; umbral_out = 2'd0; egress_count = 2'd0; dut_pops = 0;
`ifdef WEIGHTED_RR_EN
        weight_D0 = 2'd1; weight_D1 = 2'd0;
`endif
        drive();

        // Reset while ACTIVE with a pop pending, then INIT and back to IDLE
        bring_up(3);
        q0.push_back(6'h01); q0.push_back(6'h02);
        cycle();
        drive();
        #2;
        chk("t1_pop_pending", pop_D0, 1);
        reset = 1'b1;
        #1;
        chk_zero("t1_midreset");
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        init = 1'b1;
        cycle(); cycle();
        init = 1'b0;
        cycle();
        chk("t1_idle_after_init", idle_out, 1);
        q0.delete();
        cycle();

        // Threshold table: strict egress_count < umbral
        for (int i = 0; i < 8; i++) begin
            bring_up(tv[i].umb);
            q0.push_back(6'h05);
            egress_count = 2'(tv[i].egr);
            cycle();
            drive();
            #3;
            chk("thr_pop", pop_D0, tv[i].exp_pop);
            cycle();
            q0.delete();
            egress_count = 2'd0;
            run_until_idle("thr", 10);
        end

        // Single FIFO drain
        bring_up(3);
        q0.push_back(6'h0B); q0.push_back(6'h09);
        run_until_idle("t2", 20);
        exp_q.delete(); exp_q.push_back(6'h0B); exp_q.push_back(6'h09);
        chk_seq("t2_order");
        chk("t2_cnt0", cnt_D0, 2);

`ifndef WEIGHTED_RR_EN
        // Alternation when both FIFOs contend
        bring_up(3);
        q0.push_back(6'h0D); q0.push_back(6'h03);
        q1.push_back(6'h11); q1.push_back(6'h1A);
        run_until_idle("t3", 20);
        exp_q.delete();
        exp_q.push_back(6'h0D); exp_q.push_back(6'h11);
        exp_q.push_back(6'h03); exp_q.push_back(6'h1A);
        chk_seq("t3_order");
        chk("t3_cnt0", cnt_D0, 2);
        chk("t3_cnt1", cnt_D1, 2);
`endif

        // Backpressure hold and release
        bring_up(2);
        q0.push_back(6'h01); q0.push_back(6'h02); q0.push_back(6'h03);
        egress_count = 2'd2;
        dut_pops = 0;
        repeat (4) cycle();
        chk("t4_hold", dut_pops, 0);
        egress_count = 2'd1;
        cycle();
        chk("t4_resume", dut_pops, 1);
        egress_count = 2'd0;
        run_until_idle("t4", 20);

        // Misroute: word still pushed, error sticks, init clears it
        bring_up(3);
        q0.push_back(6'h1B); q0.push_back(6'h01);
        cycle();
        cycle();
        chk("t5_push",  push_out,  1);
        chk("t5_data",  data_out,  6'h1B);
        chk("t5_error", error_out, 1);
        dut_pops = 0;
        repeat (3) cycle();
        chk("t5_no_pop", dut_pops, 0);
        chk("t5_sticky", error_out, 1);
        init = 1'b1;
        cycle();
        chk("t5_cleared", error_out, 0);
        chk("t5_cnt_kept", cnt_D0, 1);
        init = 1'b0;
        run_until_idle("t5", 20);

        // Counter wrap after 256 words
        bring_up(3);
        for (int i = 0; i < 256; i++) q1.push_back(6'h10 | 6'(i % 16));
        run_until_idle("t6", 600);
        chk("t6_words", got.size(), 256);
        chk("t6_wrap", cnt_D1, 0);

`ifdef WEIGHTED_RR_EN
        // Weighted pattern D0,D0,D1 with weight_D0=1, weight_D1=0
        bring_up(3);
        for (int i = 0; i < 6; i++) begin
            q0.push_back(6'(i));
            q1.push_back(6'h10 | 6'(i));
        end
        run_until_idle("t7", 40);
        for (int k = 0; k < 9; k++) begin
            chk("t7_pattern", (k < got.size()) ? {31'd0, got[k][DEST]} : 32'hDEAD, (k % 3) == 2);
        end
`endif

        // Randomized traffic against the reference model
        bring_up(2);
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 2) == 0 && q0.size() < 8) begin
                w = 6'($urandom);
                w[DEST] = ($urandom_range(0, 59) == 0);
                q0.push_back(w);
            end
            if ($urandom_range(0, 2) == 0 && q1.size() < 8) begin
                w = 6'($urandom);
                w[DEST] = ($urandom_range(0, 59) != 0);
                q1.push_back(w);
            end
            egress_count = 2'($urandom_range(0, 3));
            init = ($urandom_range(0, 79) == 0);
            if (init) umbral_out = 2'($urandom_range(1, 3));
            cycle();
        end
        init = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
